vga_ctrl_sequencer: RTL and testbench
=====================================

# vga_ctrl_sequencer

Consumer side of the AGC gain interface: takes the 6-bit gain code produced by the gain search and drives the 64-bit thermometer `vga_control` bus to the VGA chain. Changes are slew-limited, one thermometer step at a time, so the analog gain never jumps by more than one LSB per step. It reports `busy` while moving and pulses `settled` once the VGA chain has had time to respond. It sits between the AGC core (gain and done outputs) and the analog VGA control pins.

## Interface
- `STEP_DIV`, 4: clock cycles per one-code gain step; legal range 1..16.
- `SETTLE_CYCLES`, 8: cycles to wait after reaching the target before pulsing `settled`; legal range 1..255.
- `RESET_GAIN`, 6'd32: gain code loaded at reset.

- `clk` in 1: system clock; all logic is on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `gain_in` in 6: requested gain code, 0..63.
- `gain_valid` in 1: single-cycle strobe; `gain_in` is sampled when this is high.
- `freeze` in 1: while high, stepping and settle counting pause and all state holds.
- `vga_control` out 64: thermometer code; bit i = (i <= cur_gain).
- `cur_gain` out 6: gain code currently applied.
- `busy` out 1: high when state is not IDLE.
- `settled` out 1: one-cycle pulse when a settle period completes.

## Operation
- Registers:
  - `target`: 6 bits.
  - `cur_gain`: 6 bits.
  - `div_cnt`: 4 bits.
  - `settle_cnt`: 8 bits.
  - `state`: one of {IDLE, SLEW, SETTLE}.
- Reset values:
  - `cur_gain` = `target` = `RESET_GAIN`.
  - Counters = 0.
  - `state` = IDLE.
  - `busy` = 0, `settled` = 0.
  - `vga_control` = thermometer of `RESET_GAIN`, which is 64'h0000_0001_FFFF_FFFF for the default of 32.
- IDLE + `gain_valid`:
  - `target` <= `gain_in`.
  - If `gain_in` != `cur_gain`: go to SLEW with `div_cnt` = 0.
  - Otherwise: go to SETTLE with `settle_cnt` = 0.
- SLEW:
  - `div_cnt` increments each cycle.
  - When `div_cnt` == `STEP_DIV`-1: `cur_gain` moves ±1 toward `target` and `div_cnt` <= 0.
  - If that step makes `cur_gain` == `target`: go to SETTLE with `settle_cnt` = 0.
- SETTLE:
  - `settle_cnt` increments each cycle.
  - When `settle_cnt` == `SETTLE_CYCLES`-1: `settled` <= 1 for one cycle and go to IDLE.
- Retarget: `gain_valid` in SLEW or SETTLE loads a new `target`. It is never dropped.
  - In SLEW: `div_cnt` keeps running. The step direction is re-evaluated against the new target.
  - If the new target equals `cur_gain` in SLEW: go to SETTLE with `settle_cnt` = 0.
  - In SETTLE with a new target != `cur_gain`: go to SLEW with `div_cnt` = 0.
  - In SETTLE with a new target == `cur_gain`: `settle_cnt` restarts at 0.
- `freeze` high:
  - All registers hold, including counters and state.
  - `settled` is forced to 0.
  - `gain_valid` is still captured into `target`; the state transition it implies is taken when `freeze` drops.
  - `freeze` has priority over stepping.
- Arithmetic: `cur_gain` saturates at 0 and 63 and never wraps. Stepping always converges because `target` is within 0..63.
- `vga_control` is combinational from the `cur_gain` register. Bit 0 is always 1, so minimum gain is never all-off. Bit 63 is 1 only at `cur_gain` = 63.

## Timing
- `gain_valid` at edge k, delta d = |gain_in − cur_gain| > 0:
  - `busy` high from edge k.
  - First step visible after edge k+`STEP_DIV`.
  - `cur_gain` == `target` after edge k+d·`STEP_DIV`.
  - `settled` high for the cycle after edge k+d·`STEP_DIV`+`SETTLE_CYCLES`.
  - `busy` low in that same cycle.
- d = 0: `settled` after edge k+`SETTLE_CYCLES`.
- `STEP_DIV` = 1: one step per cycle.
- Back-to-back `gain_valid` on consecutive cycles: the last value wins.
- `RESET` mid-operation returns every output to its reset value on the next edge. No `settled` pulse is emitted.

## Configuration
- `VGA_CTRL_SLEW_EN` defined: slew-limited behaviour exactly as described above.
- `VGA_CTRL_SLEW_EN` undefined:
  - SLEW state and `div_cnt` are removed.
  - `gain_valid` at edge k sets `cur_gain` = `gain_in` at edge k and enters SETTLE.
  - `settled` follows after edge k+`SETTLE_CYCLES`.
  - `STEP_DIV` is ignored.
  - `freeze` and retarget rules for SETTLE are unchanged.

## Test plan
- Reset with defaults → `cur_gain` = 32, `vga_control` = 64'h0000_0001_FFFF_FFFF, `busy` = 0, `settled` = 0.
- `gain_valid` with `gain_in` = 36 → `cur_gain` steps 33, 34, 35, 36 every 4 cycles → `settled` pulses 16+8 cycles after the strobe.
- Slewing up toward 40, at `cur_gain` = 35 issue `gain_valid` with `gain_in` = 30 → direction reverses, `cur_gain` reaches 30, exactly one `settled` pulse.
- `freeze` high for 10 cycles mid-slew from 32 to 20 → `cur_gain` and counters hold; on release, completion is delayed by exactly 10 cycles.
- Slew 32→0 and 32→63 → `vga_control` = 64'h1 and 64'hFFFF_FFFF_FFFF_FFFF, no wrap; `RESET` asserted mid-slew → `cur_gain` = 32 next cycle, no `settled` pulse.
- `VGA_CTRL_SLEW_EN` undefined, `gain_in` = 5 → `cur_gain` = 5 one cycle after the strobe, `settled` 8 cycles later.

Source files
------------

// File: rtl/vga_ctrl_sequencer_if.sv
// -----------------------------------------------------------------------------
// vga_ctrl_sequencer_if
//   Bundles the signals between the AGC core and the VGA control sequencer.
//
//   master : AGC side; drives gain_in, gain_valid and freeze, and watches the
//            sequencer status.
//   slave  : sequencer side; consumes the gain request and drives the
//            thermometer bus and the status outputs.
//
//   gain_in      [5:0]  requested gain code
//   gain_valid          single-cycle strobe qualifying gain_in
//   freeze              hold all sequencer state while high
//   vga_control  [63:0] thermometer code to the VGA chain
//   cur_gain     [5:0]  gain code currently applied
//   busy                sequencer is not idle
//   settled             one-cycle pulse when a settle period completes
// -----------------------------------------------------------------------------
interface vga_ctrl_sequencer_if;
  logic [5:0]  gain_in;
  logic        gain_valid;
  logic        freeze;
  logic [63:0] vga_control;
  logic [5:0]  cur_gain;
  logic        busy;
  logic        settled;

  modport master (
    output gain_in, gain_valid, freeze,
    input  vga_control, cur_gain, busy, settled
  );

  modport slave (
    input  gain_in, gain_valid, freeze,
    output vga_control, cur_gain, busy, settled
  );
endinterface

// File: rtl/vga_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// vga_ctrl_sequencer
//   Applies the gain code chosen by the AGC search to the 64-bit thermometer
//   control bus of the VGA chain. With VGA_CTRL_SLEW_EN defined the applied
//   code moves one step every STEP_DIV cycles toward the request; without it
//   the request is applied immediately. After the target is reached the block
//   waits SETTLE_CYCLES cycles and then pulses settled.
//
//   Optional feature macro: VGA_CTRL_SLEW_EN (slew limiting; default off).
//
//   Parameters
//     STEP_DIV       clock cycles per one-code step (1..16, slew build only)
//     SETTLE_CYCLES  cycles from reaching the target to the settled pulse (1..255)
//     RESET_GAIN     gain code applied at reset
//
//   Ports
//     clk    system clock, rising edge
//     RESET  synchronous active-high reset
//     bus    vga_ctrl_sequencer_if.slave: gain request in, control/status out
// -----------------------------------------------------------------------------
module vga_ctrl_sequencer #(
  parameter int unsigned STEP_DIV      = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic [5:0]  RESET_GAIN    = 6'd32
) (
  input  logic               clk,
  input  logic               RESET,
  vga_ctrl_sequencer_if.slave bus
);

  // Reject illegal parameter values at elaboration time.
  if (STEP_DIV < 1 || STEP_DIV > 16) begin : g_bad_step_div
    $error("vga_ctrl_sequencer: STEP_DIV must be within 1..16");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle_cycles
    $error("vga_ctrl_sequencer: SETTLE_CYCLES must be within 1..255");
  end

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

`ifdef VGA_CTRL_SLEW_EN
  localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SLEW = 2'd1, SETTLE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [5:0]  target_q, target_d;
  logic [5:0]  cur_gain_q, cur_gain_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic        settled_q, settled_d;
  // A request captured while frozen; acted on in the first unfrozen cycle.
  logic        pend_q, pend_d;
`ifdef VGA_CTRL_SLEW_EN
  logic [3:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  step_gain;
`endif

  // Target as seen this cycle: a strobe overrides the stored value at once so
  // the decision is taken on the newest request.
  logic [5:0]  eff_target;
  logic        req;

  always_comb begin
    eff_target = bus.gain_valid ? bus.gain_in : target_q;
    req        = bus.gain_valid | pend_q;
  end

`ifdef VGA_CTRL_SLEW_EN
  // One code toward the effective target, clamped so it can never wrap.
  always_comb begin
    step_gain = cur_gain_q;
    if (eff_target > cur_gain_q) begin
      if (cur_gain_q != 6'd63) step_gain = cur_gain_q + 6'd1;
    end else if (eff_target < cur_gain_q) begin
      if (cur_gain_q != 6'd0) step_gain = cur_gain_q - 6'd1;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cur_gain_d   = cur_gain_q;
    settle_cnt_d = settle_cnt_q;
    settled_d    = 1'b0;
    pend_d       = pend_q;
`ifdef VGA_CTRL_SLEW_EN
    div_cnt_d    = div_cnt_q;
`endif

    // Requests are never dropped, even while frozen.
    if (bus.gain_valid) target_d = bus.gain_in;

    if (bus.freeze) begin
      if (bus.gain_valid) pend_d = 1'b1;
    end else begin
      pend_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
`ifdef VGA_CTRL_SLEW_EN
            if (eff_target != cur_gain_q) begin
              state_d   = SLEW;
              div_cnt_d = 4'd0;
            end else begin
              state_d      = SETTLE;
              settle_cnt_d = 8'd0;
            end
`else
            cur_gain_d   = eff_target;
            state_d      = SETTLE;
            settle_cnt_d = 8'd0;
`endif
          end
        end

`ifdef VGA_CTRL_SLEW_EN
        SLEW: begin
          if (eff_target == cur_gain_q) begin
            // A retarget landed on the current code: nothing left to move.
            state_d      = SETTLE;
            settle_cnt_d = 8'd0;
          end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d  = 4'd0;
            cur_gain_d = step_gain;
            if (step_gain == eff_target) begin
              state_d      = SETTLE;
              settle_cnt_d = 8'd0;
            end
          end else begin
            div_cnt_d = div_cnt_q + 4'd1;
          end
        end
`endif

        SETTLE: begin
          if (req) begin
`ifdef VGA_CTRL_SLEW_EN
            if (eff_target != cur_gain_q) begin
              state_d   = SLEW;
              div_cnt_d = 4'd0;
            end else begin
              settle_cnt_d = 8'd0;
            end
`else
            cur_gain_d   = eff_target;
            settle_cnt_d = 8'd0;
`endif
          end else if (settle_cnt_q == SETTLE_LAST) begin
            settled_d = 1'b1;
            state_d   = IDLE;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= IDLE;
      target_q     <= RESET_GAIN;
      cur_gain_q   <= RESET_GAIN;
      settle_cnt_q <= 8'd0;
      settled_q    <= 1'b0;
      pend_q       <= 1'b0;
`ifdef VGA_CTRL_SLEW_EN
      div_cnt_q    <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cur_gain_q   <= cur_gain_d;
      settle_cnt_q <= settle_cnt_d;
      settled_q    <= settled_d;
      pend_q       <= pend_d;
`ifdef VGA_CTRL_SLEW_EN
      div_cnt_q    <= div_cnt_d;
`endif
    end
  end

  // Thermometer: bit i set when i <= cur_gain, so bit 0 is always on.
  logic [63:0] therm;
  for (genvar gi = 0; gi < 64; gi++) begin : g_therm
    assign therm[gi] = (6'(gi) <= cur_gain_q);
  end

  assign bus.vga_control = therm;
  assign bus.cur_gain    = cur_gain_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.settled     = settled_q & ~bus.freeze;

endmodule

// File: tb/tb_vga_ctrl_sequencer.sv
`timescale 1ns/1ps

`define CHECK(tag, obs, exp) \
  begin \
    n_checks++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_vga_ctrl_sequencer;
  logic clk = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   e;
  int   pulses;

  vga_ctrl_sequencer_if bus();

  vga_ctrl_sequencer #(
    .STEP_DIV      (4),
    .SETTLE_CYCLES (8),
    .RESET_GAIN    (6'd32)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [5:0] v);
    bus.gain_in    = v;
    bus.gain_valid = 1'b1;
    tick();
    bus.gain_valid = 1'b0;
  endtask

  task automatic wait_settled(input int max_edges, output int edges);
    edges = 0;
    while (edges < max_edges) begin
      tick();
      edges++;
      if (bus.settled === 1'b1) return;
    end
    edges = -1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET          = 1'b1;
    bus.gain_in    = 6'd0;
    bus.gain_valid = 1'b0;
    bus.freeze     = 1'b0;
    ticks(2);
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (bus.vga_control[i] !== (i <= 32)) begin
        n_fail++;
        $display("FAIL reset_vga_bit%0d observed=%0b expected=%0b", i, bus.vga_control[i], (i <= 32));
      end
    end
    n_checks++;
    if (bus.cur_gain !== 6'd32) begin
      n_fail++;
      $display("FAIL reset_cur_gain_direct observed=%0d expected=32", bus.cur_gain);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_direct observed=%0b expected=0", bus.busy);
    end
    n_checks++;
    if (bus.settled !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_settled_direct observed=%0b expected=0", bus.settled);
    end
    `CHECK("reset_cur_gain", bus.cur_gain, 6'd32)
    `CHECK("reset_vga", bus.vga_control, 64'h0000_0001_FFFF_FFFF)
    `CHECK("reset_busy", bus.busy, 1'b0)
    `CHECK("reset_settled", bus.settled, 1'b0)
    RESET = 1'b0;
    tick();

`ifdef VGA_CTRL_SLEW_EN
    strobe(6'd36);
    ticks(3);
    `CHECK("slew_hold_before_step", bus.cur_gain, 6'd32)
    `CHECK("slew_busy", bus.busy, 1'b1)
    tick();
    `CHECK("slew_step1", bus.cur_gain, 6'd33)
    ticks(4);
    `CHECK("slew_step2", bus.cur_gain, 6'd34)
    ticks(4);
    `CHECK("slew_step3", bus.cur_gain, 6'd35)
    ticks(4);
    `CHECK("slew_step4", bus.cur_gain, 6'd36)
    wait_settled(30, e);
    `CHECK("slew_settle_time", e, 8)
    `CHECK("slew_busy_low_at_settled", bus.busy, 1'b0)

    RESET = 1'b1; tick(); RESET = 1'b0;
    strobe(6'd40);
    ticks(12);
    `CHECK("rev_at_35", bus.cur_gain, 6'd35)
    strobe(6'd30);
    wait_settled(40, e);
    `CHECK("rev_settle_time", e, 27)
    `CHECK("rev_final_gain", bus.cur_gain, 6'd30)
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.settled === 1'b1) pulses++;
    end
    `CHECK("rev_single_pulse", pulses, 0)

    RESET = 1'b1; tick(); RESET = 1'b0;
    strobe(6'd20);
    ticks(5);
    `CHECK("frz_before", bus.cur_gain, 6'd31)
    bus.freeze = 1'b1;
    ticks(10);
    `CHECK("frz_hold", bus.cur_gain, 6'd31)
    bus.freeze = 1'b0;
    wait_settled(100, e);
    `CHECK("frz_settle_time", e, 51)
    `CHECK("frz_final_gain", bus.cur_gain, 6'd20)

    strobe(6'd0);
    wait_settled(200, e);
    `CHECK("to0_settle_time", e, 88)
    `CHECK("to0_vga", bus.vga_control, 64'h1)
    strobe(6'd63);
    wait_settled(300, e);
    `CHECK("to63_settle_time", e, 260)
    `CHECK("to63_vga", bus.vga_control, 64'hFFFF_FFFF_FFFF_FFFF)

    strobe(6'd40);
    ticks(10);
    RESET = 1'b1;
    tick();
    `CHECK("rst_mid_cur_gain", bus.cur_gain, 6'd32)
    `CHECK("rst_mid_busy", bus.busy, 1'b0)
    `CHECK("rst_mid_settled", bus.settled, 1'b0)
    RESET = 1'b0;
    wait_settled(20, e);
    `CHECK("rst_mid_no_pulse", e, -1)
`else
    strobe(6'd5);
    `CHECK("imm_cur_gain", bus.cur_gain, 6'd5)
    `CHECK("imm_vga", bus.vga_control, 64'h3F)
    `CHECK("imm_busy", bus.busy, 1'b1)
    `CHECK("imm_settled_low", bus.settled, 1'b0)
    wait_settled(20, e);
    `CHECK("imm_settle_time", e, 8)
    `CHECK("imm_busy_low_at_settled", bus.busy, 1'b0)
    tick();
    `CHECK("imm_pulse_one_cycle", bus.settled, 1'b0)

    strobe(6'd63);
    `CHECK("max_vga", bus.vga_control, 64'hFFFF_FFFF_FFFF_FFFF)
    wait_settled(20, e);
    `CHECK("max_settle_time", e, 8)
    strobe(6'd0);
    `CHECK("min_vga", bus.vga_control, 64'h1)
    wait_settled(20, e);
    `CHECK("min_settle_time", e, 8)

    strobe(6'd10);
    ticks(3);
    strobe(6'd20);
    `CHECK("retgt_cur_gain", bus.cur_gain, 6'd20)
    wait_settled(20, e);
    `CHECK("retgt_settle_time", e, 8)

    strobe(6'd40);
    ticks(2);
    bus.freeze = 1'b1;
    ticks(5);
    `CHECK("frz_busy", bus.busy, 1'b1)
    `CHECK("frz_settled_low", bus.settled, 1'b0)
    bus.freeze = 1'b0;
    wait_settled(20, e);
    `CHECK("frz_settle_time", e, 6)

    bus.freeze = 1'b1;
    strobe(6'd7);
    `CHECK("frz_cap_hold", bus.cur_gain, 6'd40)
    `CHECK("frz_cap_idle", bus.busy, 1'b0)
    tick();
    `CHECK("frz_cap_hold2", bus.cur_gain, 6'd40)
    bus.freeze = 1'b0;
    tick();
    `CHECK("frz_cap_apply", bus.cur_gain, 6'd7)
    `CHECK("frz_cap_busy", bus.busy, 1'b1)
    wait_settled(20, e);
    `CHECK("frz_cap_settle_time", e, 8)

    bus.gain_in    = 6'd11;
    bus.gain_valid = 1'b1;
    tick();
    bus.gain_in    = 6'd12;
    tick();
    bus.gain_valid = 1'b0;
    `CHECK("b2b_last_wins", bus.cur_gain, 6'd12)
    wait_settled(20, e);
    `CHECK("b2b_settle_time", e, 8)

    strobe(6'd50);
    ticks(3);
    RESET = 1'b1;
    tick();
    `CHECK("rst_mid_cur_gain", bus.cur_gain, 6'd32)
    `CHECK("rst_mid_vga", bus.vga_control, 64'h0000_0001_FFFF_FFFF)
    `CHECK("rst_mid_busy", bus.busy, 1'b0)
    `CHECK("rst_mid_settled", bus.settled, 1'b0)
    RESET = 1'b0;
    wait_settled(12, e);
    `CHECK("rst_mid_no_pulse", e, -1)
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
